// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle sequencer: FSM states, opcodes,
// sub-op codes, ALU operations and operand/memory select encodings.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED
    } state_t;

    typedef enum logic [2:0] {
        OP_DBNZ    = 3'd0,
        OP_LDABS   = 3'd1,
        OP_BN      = 3'd2,
        OP_COPY    = 3'd3,
        OP_T1_NONE = 3'd4,
        OP_T1_IMM  = 3'd5,
        OP_T1_REG  = 3'd6,
        OP_T1_REG2 = 3'd7
    } opcode_t;

    // Sub-op codes live in field A of the type1 opcodes
    localparam int SUB_HALT   = 0;
    localparam int SUB_NOP    = 1;
    localparam int SUB_CLROFF = 2;

    localparam int SUB_LDADDR = 0;
    localparam int SUB_STORE  = 1;
    localparam int SUB_SETOFF = 2;
    localparam int SUB_ADDI   = 3;

    localparam int SUB_RET    = 0;
    localparam int SUB_LOAD   = 1;
    localparam int SUB_LDSM   = 2;
    localparam int SUB_ADD    = 3;

    localparam int SUB_SPC2   = 0;

    localparam int STRMATCH_REG = 2;

    typedef enum logic [3:0] {
        ALU_DO_NOTHING = 4'd0,
        ALU_ADD        = 4'd1,
        ALU_DEC        = 4'd2,
        ALU_PASS_A     = 4'd3,
        ALU_PASS_B     = 4'd4,
        ALU_ABS_DIFF   = 4'd5,
        ALU_ADDU_TWO   = 4'd6,
        ALU_STR_MATCH  = 4'd7
    } alu_op_t;

    localparam logic [3:0] ASEL_REG = 4'd0;
    localparam logic [3:0] ASEL_IMM = 4'd1;
    localparam logic [3:0] ASEL_MEM = 4'd2;

    localparam logic [3:0] BSEL_REG = 4'd0;
    localparam logic [3:0] BSEL_IMM = 4'd1;
    localparam logic [3:0] BSEL_ONE = 4'd2;

    localparam logic MADDR_IMM = 1'b0;
    localparam logic MADDR_REG = 1'b1;

    typedef enum logic [1:0] {
        BR_SEQ,
        BR_DBNZ,
        BR_BN,
        BR_RET
    } branch_t;

    typedef struct packed {
        alu_op_t    alu_op;
        logic [3:0] a_sel;
        logic [3:0] b_sel;
        logic       mem_addr_sel;
        logic       is_mem;
        logic       is_store;
        logic       is_halt;
        logic       is_write;
        logic       is_offset;
        logic       imm_pc;
        logic       imm_ret;
        branch_t    branch;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational instruction decoder: ir -> control bundle and register
// indices. Unknown opcodes and unused sub-codes fall out as NOPs.
module instr_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W  = 3,
    parameter int FLD_W = 3
) (
    input  logic [OP_W+2*FLD_W-1:0] ir,
    output ctrl_t                   ctrl,
    output logic [FLD_W-1:0]        src_a,
    output logic [FLD_W-1:0]        src_b,
    output logic [FLD_W-1:0]        src_write
);

    localparam int IW = OP_W + 2*FLD_W;

    logic [OP_W-1:0]  op;
    logic [FLD_W-1:0] fa;
    logic [FLD_W-1:0] fb;
    logic             op_known;

    assign op = ir[IW-1 -: OP_W];
    assign fa = ir[2*FLD_W-1 -: FLD_W];
    assign fb = ir[FLD_W-1:0];

    if (OP_W > 3) begin : g_wide_op
        assign op_known = ~|op[OP_W-1:3];
    end else begin : g_base_op
        assign op_known = 1'b1;
    end

    always_comb begin
        ctrl      = '0;
        src_a     = '0;
        src_b     = '0;
        src_write = '0;
        if (op_known) begin
            unique case (opcode_t'(op[2:0]))
                OP_DBNZ: begin
                    src_a         = fa;
                    src_write     = fa;
                    ctrl.alu_op   = ALU_DEC;
                    ctrl.a_sel    = ASEL_REG;
                    ctrl.b_sel    = BSEL_ONE;
                    ctrl.is_write = 1'b1;
                    ctrl.branch   = BR_DBNZ;
                end
                OP_LDABS: begin
                    src_a             = fa;
                    src_b             = fb;
                    src_write         = fb;
                    ctrl.alu_op       = ALU_ABS_DIFF;
                    ctrl.a_sel        = ASEL_MEM;
                    ctrl.b_sel        = BSEL_REG;
                    ctrl.mem_addr_sel = MADDR_REG;
                    ctrl.is_mem       = 1'b1;
                    ctrl.is_write     = 1'b1;
                end
                OP_BN: begin
                    ctrl.branch = BR_BN;
                end
                OP_COPY: begin
                    src_b         = fb;
                    src_write     = fa;
                    ctrl.alu_op   = ALU_PASS_B;
                    ctrl.b_sel    = BSEL_REG;
                    ctrl.is_write = 1'b1;
                end
                OP_T1_NONE: begin
                    case (fa)
                        FLD_W'(SUB_HALT):   ctrl.is_halt   = 1'b1;
                        FLD_W'(SUB_CLROFF): ctrl.is_offset = 1'b1;
                        default: ;
                    endcase
                end
                OP_T1_IMM: begin
                    case (fa)
                        FLD_W'(SUB_LDADDR): begin
                            ctrl.alu_op       = ALU_PASS_A;
                            ctrl.a_sel        = ASEL_MEM;
                            ctrl.mem_addr_sel = MADDR_IMM;
                            ctrl.is_mem       = 1'b1;
                            ctrl.is_write     = 1'b1;
                        end
                        FLD_W'(SUB_STORE): begin
                            ctrl.mem_addr_sel = MADDR_IMM;
                            ctrl.is_mem       = 1'b1;
                            ctrl.is_store     = 1'b1;
                        end
                        FLD_W'(SUB_SETOFF): begin
                            ctrl.alu_op    = ALU_PASS_B;
                            ctrl.b_sel     = BSEL_IMM;
                            ctrl.is_offset = 1'b1;
                        end
                        FLD_W'(SUB_ADDI): begin
                            ctrl.alu_op   = ALU_ADD;
                            ctrl.a_sel    = ASEL_REG;
                            ctrl.b_sel    = BSEL_IMM;
                            ctrl.is_write = 1'b1;
                        end
                        default: ;
                    endcase
                end
                OP_T1_REG: begin
                    case (fa)
                        FLD_W'(SUB_RET): begin
                            src_a        = fb;
                            ctrl.imm_ret = 1'b1;
                            ctrl.branch  = BR_RET;
                        end
                        FLD_W'(SUB_LOAD): begin
                            src_a             = fb;
                            ctrl.alu_op       = ALU_PASS_A;
                            ctrl.a_sel        = ASEL_MEM;
                            ctrl.mem_addr_sel = MADDR_REG;
                            ctrl.is_mem       = 1'b1;
                            ctrl.is_write     = 1'b1;
                        end
                        FLD_W'(SUB_LDSM): begin
                            src_a             = fb;
                            src_b             = FLD_W'(STRMATCH_REG);
                            src_write         = FLD_W'(STRMATCH_REG);
                            ctrl.alu_op       = ALU_STR_MATCH;
                            ctrl.a_sel        = ASEL_MEM;
                            ctrl.b_sel        = BSEL_REG;
                            ctrl.mem_addr_sel = MADDR_REG;
                            ctrl.is_mem       = 1'b1;
                            ctrl.is_write     = 1'b1;
                        end
                        FLD_W'(SUB_ADD): begin
                            src_b         = fb;
                            ctrl.alu_op   = ALU_ADD;
                            ctrl.a_sel    = ASEL_REG;
                            ctrl.b_sel    = BSEL_REG;
                            ctrl.is_write = 1'b1;
                        end
                        default: ;
                    endcase
                end
                OP_T1_REG2: begin
                    case (fa)
                        FLD_W'(SUB_SPC2): begin
                            src_write     = fb;
                            ctrl.alu_op   = ALU_ADDU_TWO;
                            ctrl.a_sel    = ASEL_IMM;
                            ctrl.imm_pc   = 1'b1;
                            ctrl.is_write = 1'b1;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer: owns pc/ir/return register and steps each
// instruction through FETCH, EXEC, MEM and WB.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OP_W  = 3,
    parameter int FLD_W = 3,
    parameter int PC_W  = 7,
    parameter int IMM_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [OP_W+2*FLD_W-1:0] instr,
    input  logic                    alu_flag,
    input  logic [PC_W-1:0]         reg_a_data,
    output logic [PC_W-1:0]         pc,
    output logic [FLD_W-1:0]        src_a,
    output logic [FLD_W-1:0]        src_b,
    output logic [FLD_W-1:0]        src_write,
    output logic                    reg_write,
    output logic [3:0]              alu_op,
    output logic [3:0]              alu_a_sel,
    output logic [3:0]              alu_b_sel,
    output logic [IMM_W-1:0]        intermediate,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic                    mem_addr_sel,
    input  logic                    mem_ack,
    output logic                    mem_offset_write,
    output logic                    busy,
    output logic                    halted
);

    localparam int IW = OP_W + 2*FLD_W;

    state_t           state;
    state_t           state_nx;
    logic [IW-1:0]    ir;
    logic [PC_W-1:0]  ret;
    logic             flag_q;
    logic             go;
    logic             pc_upd;
    logic [PC_W-1:0]  pc_nx;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  off_b;
    logic [PC_W-1:0]  off_ba;
    logic [FLD_W-1:0] fa;
    logic [FLD_W-1:0] fb;
    logic             active;

    ctrl_t            ctl;
    logic [FLD_W-1:0] dec_a;
    logic [FLD_W-1:0] dec_b;
    logic [FLD_W-1:0] dec_w;

    instr_decode #(
        .OP_W  (OP_W),
        .FLD_W (FLD_W)
    ) u_decode (
        .ir        (ir),
        .ctrl      (ctl),
        .src_a     (dec_a),
        .src_b     (dec_b),
        .src_write (dec_w)
    );

    assign fa     = ir[2*FLD_W-1 -: FLD_W];
    assign fb     = ir[FLD_W-1:0];
    assign pc_inc = pc + PC_W'(1);
    assign off_b  = PC_W'($signed(fb));
    assign off_ba = PC_W'($signed({fb, fa}));

    // Branch target; the DBNZ flag was captured while the ALU ran in EXEC
    always_comb begin
        pc_nx = pc_inc;
        unique case (ctl.branch)
            BR_DBNZ: pc_nx = flag_q ? pc_inc : pc + off_b;
            BR_BN:   pc_nx = pc + off_ba;
            BR_RET:  pc_nx = reg_a_data;
            default: pc_nx = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= '0;
            ir     <= '0;
            ret    <= '0;
            flag_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_FETCH) ir <= instr;
            if (state == S_EXEC) flag_q <= alu_flag;
            if (state == S_WB && ctl.imm_pc) ret <= pc + PC_W'(2);
            if (go) pc <= '0;
            else if (pc_upd) pc <= pc_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        go               = 1'b0;
        pc_upd           = 1'b0;
        reg_write        = 1'b0;
        mem_req          = 1'b0;
        mem_offset_write = 1'b0;
        busy             = 1'b1;
        halted           = 1'b0;
        case (state)
            S_IDLE, S_HALTED: begin
                busy   = 1'b0;
                halted = (state == S_HALTED);
                if (start) begin
                    go       = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: state_nx = S_EXEC;
            S_EXEC: begin
                if (ctl.is_mem) state_nx = S_MEM;
                else if (ctl.is_halt) state_nx = S_HALTED;
                else state_nx = S_WB;
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    if (ctl.is_store) begin
                        pc_upd   = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write        = ctl.is_write;
                mem_offset_write = ctl.is_offset;
                pc_upd           = 1'b1;
                state_nx         = S_FETCH;
            end
            default: begin
                busy     = 1'b0;
                state_nx = S_IDLE;
            end
        endcase
    end

    assign active = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

    always_comb begin
        src_a        = '0;
        src_b        = '0;
        src_write    = '0;
        alu_op       = ALU_DO_NOTHING;
        alu_a_sel    = '0;
        alu_b_sel    = '0;
        intermediate = '0;
        mem_addr_sel = 1'b0;
        if (active) begin
            src_a        = dec_a;
            src_b        = dec_b;
            src_write    = dec_w;
            alu_op       = ctl.alu_op;
            alu_a_sel    = ctl.a_sel;
            alu_b_sel    = ctl.b_sel;
            mem_addr_sel = ctl.mem_addr_sel;
            if (ctl.imm_pc) intermediate = IMM_W'(pc);
            else if (ctl.imm_ret) intermediate = IMM_W'(ret);
            else intermediate = IMM_W'(fb);
        end
    end

    assign mem_we = mem_req & ctl.is_store;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: reset, memory latency, branches,
// pc wrap, call/return, halt/restart and reset during a memory access.
module tb_multicycle_control;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [8:0] instr;
    logic       alu_flag;
    logic [6:0] reg_a_data;
    logic [6:0] pc;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic [2:0] src_write;
    logic       reg_write;
    logic [3:0] alu_op;
    logic [3:0] alu_a_sel;
    logic [3:0] alu_b_sel;
    logic [7:0] intermediate;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       mem_ack;
    logic       mem_offset_write;
    logic       busy;
    logic       halted;

    logic [8:0] prog [128];
    int n_chk  = 0;
    int n_pass = 0;

    multicycle_control dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .instr            (instr),
        .alu_flag         (alu_flag),
        .reg_a_data       (reg_a_data),
        .pc               (pc),
        .src_a            (src_a),
        .src_b            (src_b),
        .src_write        (src_write),
        .reg_write        (reg_write),
        .alu_op           (alu_op),
        .alu_a_sel        (alu_a_sel),
        .alu_b_sel        (alu_b_sel),
        .intermediate     (intermediate),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr_sel     (mem_addr_sel),
        .mem_ack          (mem_ack),
        .mem_offset_write (mem_offset_write),
        .busy             (busy),
        .halted           (halted)
    );

    always #5 clk = ~clk;

    assign instr = prog[pc];

    function automatic logic [8:0] enc(input int op, input int a, input int b);
        logic [31:0] o, x, y;
        o = op;
        x = a;
        y = b;
        return {o[2:0], x[2:0], y[2:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) prog[i] = enc(4, 1, 0);
        prog[0]   = enc(5, 0, 5);
        prog[1]   = enc(2, 1, 1);
        prog[10]  = enc(0, 2, 7);
        prog[9]   = enc(3, 1, 2);
        prog[11]  = enc(2, 3, 6);
        prog[126] = enc(2, 5, 0);
        prog[3]   = enc(2, 4, 7);
        prog[127] = enc(5, 3, 1);
        prog[20]  = enc(7, 0, 4);
        prog[21]  = enc(6, 0, 5);
        prog[22]  = enc(5, 1, 6);
        prog[23]  = enc(5, 2, 3);
        prog[24]  = enc(6, 7, 0);
        prog[25]  = enc(4, 0, 0);

        rst_n      = 1'b0;
        start      = 1'b0;
        mem_ack    = 1'b0;
        alu_flag   = 1'b0;
        reg_a_data = 7'd0;
        step();
        step();
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_strobes", {reg_write, mem_req, mem_offset_write}, 0);
        chk("rst_alu_op", alu_op, ALU_DO_NOTHING);
        chk("rst_idx", {src_a, src_b, src_write}, 0);
        rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // loadFromAddress B=5, ack on the 4th MEM cycle
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_pc", pc, 0);
        chk("start_busy", busy, 1);
        step();
        chk("ld_exec_req", mem_req, 0);
        chk("ld_exec_imm", intermediate, 5);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ld_mem_req", mem_req, 1);
            chk("ld_mem_imm", intermediate, 5);
            chk("ld_mem_sel", mem_addr_sel, 0);
            chk("ld_mem_we", mem_we, 0);
            if (i == 3) mem_ack = 1'b1;
        end
        step();
        mem_ack = 1'b0;
        chk("ld_wb_req", mem_req, 0);
        chk("ld_wb_wr", reg_write, 1);
        chk("ld_wb_dst", src_write, 0);
        step();
        chk("ld_pc", pc, 1);
        chk("ld_fetch_wr", reg_write, 0);

        // BN +9 -> 10
        step();
        step();
        chk("bn_wb_wr", reg_write, 0);
        step();
        chk("bn_pc", pc, 10);

        // DBNZ -1 with flag 0 -> 9 (flag sampled in EXEC only)
        step();
        alu_flag = 1'b0;
        chk("dbnz_dst", src_write, 2);
        chk("dbnz_op", alu_op, ALU_DEC);
        step();
        alu_flag = 1'b1;
        chk("dbnz_wr", reg_write, 1);
        step();
        alu_flag = 1'b0;
        chk("dbnz_taken_pc", pc, 9);

        // copy at 9; start while busy is ignored
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("copy_wr", reg_write, 1);
        chk("copy_dst", src_write, 1);
        step();
        chk("copy_pc", pc, 10);
        chk("copy_busy", busy, 1);

        // DBNZ with flag 1 -> 11
        step();
        alu_flag = 1'b1;
        step();
        alu_flag = 1'b0;
        step();
        chk("dbnz_fall_pc", pc, 11);

        // BN -13 -> 126, BN +5 wraps -> 3, BN -4 -> 127
        step(); step(); step();
        chk("bn_neg_pc", pc, 126);
        step(); step(); step();
        chk("bn_wrap_pc", pc, 3);
        step(); step(); step();
        chk("bn_back_pc", pc, 127);

        // addi at 127 wraps to 0
        step();
        step();
        chk("addi_wr", reg_write, 1);
        step();
        chk("seq_wrap_pc", pc, 0);
        prog[1] = enc(2, 3, 2);

        // load again with minimum latency
        step();
        step();
        chk("ld1_req", mem_req, 1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("ld1_wb_req", mem_req, 0);
        chk("ld1_wb_wr", reg_write, 1);
        step();
        chk("ld1_pc", pc, 1);

        // BN +19 -> 20
        step(); step(); step();
        chk("bn_call_pc", pc, 20);

        // storePCPlusTwo at 20
        step();
        chk("spc2_imm", intermediate, 20);
        chk("spc2_op", alu_op, ALU_ADDU_TWO);
        step();
        chk("spc2_wr", reg_write, 1);
        chk("spc2_dst", src_write, 4);
        step();
        chk("spc2_pc", pc, 21);

        // Return via reg_a_data
        reg_a_data = 7'd22;
        step();
        chk("ret_src", src_a, 5);
        step();
        chk("ret_wr", reg_write, 0);
        step();
        chk("ret_pc", pc, 22);

        // store, L=2 -> straight back to FETCH
        step();
        step();
        chk("st_req1", mem_req, 1);
        chk("st_we1", mem_we, 1);
        step();
        chk("st_req2", mem_req, 1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("st_pc", pc, 23);
        chk("st_after", {reg_write, mem_req}, 0);

        // setMemOffset
        step();
        step();
        chk("off_strobe", mem_offset_write, 1);
        chk("off_wr", reg_write, 0);
        step();
        chk("off_pc", pc, 24);
        chk("off_drop", mem_offset_write, 0);

        // unused sub-code acts as NOP
        step();
        step();
        chk("nop_wb", {reg_write, mem_req, mem_offset_write}, 0);
        step();
        chk("nop_pc", pc, 25);

        // HALT
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            chk("halt_flags", {halted, busy}, 2'b10);
            chk("halt_strobes", {reg_write, mem_req, mem_offset_write}, 0);
            step();
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_pc", pc, 0);
        chk("restart_flags", {halted, busy}, 2'b01);

        // reset in the middle of a memory access
        step();
        step();
        chk("mem_before_rst", mem_req, 1);
        rst_n = 1'b0;
        step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_busy", busy, 0);
        chk("rst_mem_pc", pc, 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", {busy, halted}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
